// File: rtl/gpio_serial_port.sv
// Half-duplex serial GPIO port: start + DATA_W data bits + optional parity + stop, with valid/ready on both paths.
// Define GPIO_SERIAL_PARITY_EN to insert and check an even-parity bit between the data and the stop bit.
module gpio_serial_port #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              direction,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              gpio_in,
    output logic              gpio_out,
    output logic              gpio_oe,
    output logic              tx_done,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_parity_err
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef GPIO_SERIAL_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    logic sync1, sync2, line, line_prev;
    logic abort, rx_run;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= gpio_in;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign line = sync2;
    // gpio_oe is the registered direction, so any difference means the mode just flipped
    assign abort  = direction ^ gpio_oe;
    assign rx_run = ~direction & ~gpio_oe;

    logic [2:0]        tx_state;
    logic [DIV_W-1:0]  tx_timer, tx_div;
    logic              tx_msb;
    logic [DATA_W-1:0] tx_shreg, tx_shifted;
    logic [CNT_W-1:0]  tx_cnt;
    logic              tx_bit, tx_tick;
`ifdef GPIO_SERIAL_PARITY_EN
    logic              tx_par;
`endif

    assign tx_ready   = (tx_state == ST_IDLE) & direction & gpio_oe;
    assign tx_tick    = (tx_timer == '0);
    assign tx_bit     = tx_msb ? tx_shreg[DATA_W-1] : tx_shreg[0];
    assign tx_shifted = tx_msb ? {tx_shreg[DATA_W-2:0], 1'b0} : {1'b0, tx_shreg[DATA_W-1:1]};

    // The last stop cycle overlaps IDLE, so a queued word starts with no idle gap
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            tx_state <= ST_IDLE;
            tx_timer <= '0;
            tx_div   <= '0;
            tx_msb   <= 1'b0;
            tx_shreg <= '0;
            tx_cnt   <= '0;
            gpio_out <= 1'b1;
            gpio_oe  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef GPIO_SERIAL_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            gpio_oe <= direction;
            tx_done <= 1'b0;
            if (abort) begin
                tx_state <= ST_IDLE;
                gpio_out <= 1'b1;
            end else begin
                case (tx_state)
                    ST_IDLE: if (tx_valid && tx_ready) begin
                        tx_shreg <= tx_data;
                        tx_msb   <= msb_first;
                        tx_div   <= baud_div;
                        tx_timer <= baud_div;
                        gpio_out <= 1'b0;
                        tx_state <= ST_START;
`ifdef GPIO_SERIAL_PARITY_EN
                        tx_par   <= ^tx_data;
`endif
                    end
                    ST_START: if (tx_tick) begin
                        gpio_out <= tx_bit;
                        tx_shreg <= tx_shifted;
                        tx_cnt   <= '0;
                        tx_timer <= tx_div;
                        tx_state <= ST_DATA;
                    end else tx_timer <= tx_timer - DIV_W'(1);
                    ST_DATA: if (tx_tick) begin
                        if (tx_cnt == LAST_BIT) begin
`ifdef GPIO_SERIAL_PARITY_EN
                            gpio_out <= tx_par;
                            tx_timer <= tx_div;
                            tx_state <= ST_PARITY;
`else
                            gpio_out <= 1'b1;
                            if (tx_div == '0) begin
                                tx_state <= ST_IDLE;
                                tx_done  <= 1'b1;
                            end else begin
                                tx_timer <= tx_div - DIV_W'(1);
                                tx_state <= ST_STOP;
                            end
`endif
                        end else begin
                            gpio_out <= tx_bit;
                            tx_shreg <= tx_shifted;
                            tx_cnt   <= tx_cnt + CNT_W'(1);
                            tx_timer <= tx_div;
                        end
                    end else tx_timer <= tx_timer - DIV_W'(1);
`ifdef GPIO_SERIAL_PARITY_EN
                    ST_PARITY: if (tx_tick) begin
                        gpio_out <= 1'b1;
                        if (tx_div == '0) begin
                            tx_state <= ST_IDLE;
                            tx_done  <= 1'b1;
                        end else begin
                            tx_timer <= tx_div - DIV_W'(1);
                            tx_state <= ST_STOP;
                        end
                    end else tx_timer <= tx_timer - DIV_W'(1);
`endif
                    ST_STOP: if (tx_tick) begin
                        tx_state <= ST_IDLE;
                        tx_done  <= 1'b1;
                    end else tx_timer <= tx_timer - DIV_W'(1);
                    default: tx_state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [2:0]        rx_state;
    logic [DIV_W-1:0]  rx_timer, rx_div;
    logic              rx_msb;
    logic [DATA_W-1:0] rx_shreg;
    logic [CNT_W-1:0]  rx_cnt;
    logic              rx_tick, stop_sample, good_stop;
`ifdef GPIO_SERIAL_PARITY_EN
    logic              rx_par;
`endif

    assign rx_tick = (rx_timer == '0);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rx_state <= ST_IDLE;
            rx_timer <= '0;
            rx_div   <= '0;
            rx_msb   <= 1'b0;
            rx_shreg <= '0;
            rx_cnt   <= '0;
`ifdef GPIO_SERIAL_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else if (!rx_run) begin
            rx_state <= ST_IDLE;
        end else begin
            case (rx_state)
                ST_IDLE: if (line_prev && !line) begin
                    rx_timer <= baud_div >> 1;
                    rx_div   <= baud_div;
                    rx_msb   <= msb_first;
                    rx_state <= ST_START;
                end
                ST_START: if (rx_tick) begin
                    rx_timer <= rx_div;
                    rx_cnt   <= '0;
                    rx_state <= line ? ST_IDLE : ST_DATA;
`ifdef GPIO_SERIAL_PARITY_EN
                    rx_par   <= 1'b0;
`endif
                end else rx_timer <= rx_timer - DIV_W'(1);
                ST_DATA: if (rx_tick) begin
                    rx_shreg <= rx_msb ? {rx_shreg[DATA_W-2:0], line} : {line, rx_shreg[DATA_W-1:1]};
                    rx_timer <= rx_div;
                    rx_cnt   <= rx_cnt + CNT_W'(1);
`ifdef GPIO_SERIAL_PARITY_EN
                    rx_par   <= rx_par ^ line;
                    if (rx_cnt == LAST_BIT) rx_state <= ST_PARITY;
`else
                    if (rx_cnt == LAST_BIT) rx_state <= ST_STOP;
`endif
                end else rx_timer <= rx_timer - DIV_W'(1);
`ifdef GPIO_SERIAL_PARITY_EN
                ST_PARITY: if (rx_tick) begin
                    rx_par   <= rx_par ^ line;
                    rx_timer <= rx_div;
                    rx_state <= ST_STOP;
                end else rx_timer <= rx_timer - DIV_W'(1);
`endif
                ST_STOP: if (rx_tick) begin
                    rx_state <= line ? ST_IDLE : ST_BREAK;
                end else rx_timer <= rx_timer - DIV_W'(1);
                ST_BREAK: if (line) rx_state <= ST_IDLE;
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign stop_sample  = rx_run & (rx_state == ST_STOP) & rx_tick;
    assign rx_frame_err = stop_sample & ~line;
`ifdef GPIO_SERIAL_PARITY_EN
    assign rx_parity_err = stop_sample & line & rx_par;
    assign good_stop     = stop_sample & line & ~rx_par;
`else
    assign rx_parity_err = 1'b0;
    assign good_stop     = stop_sample & line;
`endif
    assign rx_overrun = good_stop & rx_valid & ~rx_ready;

    // A word completing in the same cycle the consumer takes the old one simply replaces it
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (good_stop && (!rx_valid || rx_ready)) begin
            rx_data  <= rx_shreg;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule
